alu_exec_ctrl: RTL and testbench

Multi-cycle execute sequencer that drives the 18-bit AND/ADD/OR/XOR ALU. It is the initiator side of the ALU interface.
- Fetches 18-bit instructions over a req/valid handshake and decodes them.
- Reads operands from an internal 16x18 register file, presents A/B/select to the ALU, captures result and carry, and writes back.
- Sits between instruction memory and the ALU in the CPU datapath.

---
 rtl/alu_exec_pkg.sv | 43 ++++
 rtl/exec_regfile.sv | 37 +++
 rtl/alu_exec_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared constants, state encoding and instruction field layout for the
// ALU execute sequencer.
package alu_exec_pkg;

    localparam int DW     = 18;
    localparam int NREG   = 16;
    localparam int PC_W   = 8;
    localparam int RIDX_W = 4;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [DW-1:0] HALT_INSTR = 18'h00000;

    // Instruction field bit positions
    localparam int OP_HI   = 17;
    localparam int OP_LO   = 16;
    localparam int IMM_BIT = 15;
    localparam int RD_HI   = 14;
    localparam int RD_LO   = 11;
    localparam int RS1_HI  = 10;
    localparam int RS1_LO  = 7;
    localparam int RS2_HI  = 6;
    localparam int RS2_LO  = 3;
    localparam int IMM7_HI = 6;
    localparam int IMM7_LO = 0;

    // Zero-extend the 7-bit immediate field of an instruction word
    function automatic logic [DW-1:0] imm7_zext(input logic [DW-1:0] ir);
        return {11'b000_0000_0000, ir[IMM7_HI:IMM7_LO]};
    endfunction

endpackage

// File: rtl/exec_regfile.sv
// 16-entry register file: r0 reads as zero, two operand read ports,
// one debug read port and one synchronous write port.
module exec_regfile
    import alu_exec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [RIDX_W-1:0] raddr1,
    output logic [DW-1:0]     rdata1,
    input  logic [RIDX_W-1:0] raddr2,
    output logic [DW-1:0]     rdata2,
    input  logic [RIDX_W-1:0] dbg_addr,
    output logic [DW-1:0]     dbg_data
);

    logic [DW-1:0] mem_r [NREG];

    // Register storage: cleared on reset, written when enabled (r0 never written)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (we && (waddr != 4'd0)) begin
            mem_r[waddr] <= wdata;
        end
    end

    // r0 is forced to zero on every read port regardless of storage contents
    assign rdata1   = (raddr1   == 4'd0) ? {DW{1'b0}} : mem_r[raddr1];
    assign rdata2   = (raddr2   == 4'd0) ? {DW{1'b0}} : mem_r[raddr2];
    assign dbg_data = (dbg_addr == 4'd0) ? {DW{1'b0}} : mem_r[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute sequencer: fetch, decode, drive the external ALU,
// capture result/carry and write back to the register file.
module alu_exec_ctrl
    import alu_exec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              instr_req,
    output logic [PC_W-1:0]   instr_addr,
    input  logic              instr_valid,
    input  logic [DW-1:0]     instr_data,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic [1:0]        alu_sel,
    input  logic [DW-1:0]     alu_out,
    input  logic              alu_carry,
    output logic              busy,
    output logic              halted,
    output logic              carry_flag,
    output logic [PC_W-1:0]   pc,
    input  logic [RIDX_W-1:0] dbg_addr,
    output logic [DW-1:0]     dbg_data
);

    state_t            state_r;
    logic [PC_W-1:0]   pc_r;
    logic [DW-1:0]     ir_r;
    logic [DW-1:0]     res_r;
    logic [DW-1:0]     alu_a_r;
    logic [DW-1:0]     alu_b_r;
    logic [1:0]        alu_sel_r;
    logic              instr_req_r;
    logic              busy_r;
    logic              halted_r;
    logic              carry_flag_r;

    logic [1:0]        op_s;
    logic              imm_s;
    logic [RIDX_W-1:0] rd_s;
    logic [RIDX_W-1:0] rs1_s;
    logic [RIDX_W-1:0] rs2_s;
    logic [DW-1:0]     rs1_data_s;
    logic [DW-1:0]     rs2_data_s;
    logic              wb_en_s;

    assign op_s    = ir_r[OP_HI:OP_LO];
    assign imm_s   = ir_r[IMM_BIT];
    assign rd_s    = ir_r[RD_HI:RD_LO];
    assign rs1_s   = ir_r[RS1_HI:RS1_LO];
    assign rs2_s   = ir_r[RS2_HI:RS2_LO];
    assign wb_en_s = (state_r == WB);

    exec_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (wb_en_s),
        .waddr    (rd_s),
        .wdata    (res_r),
        .raddr1   (rs1_s),
        .rdata1   (rs1_data_s),
        .raddr2   (rs2_s),
        .rdata2   (rs2_data_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Sequencer FSM with all externally visible controls held in registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            pc_r         <= {PC_W{1'b0}};
            ir_r         <= {DW{1'b0}};
            res_r        <= {DW{1'b0}};
            alu_a_r      <= {DW{1'b0}};
            alu_b_r      <= {DW{1'b0}};
            alu_sel_r    <= OP_AND;
            instr_req_r  <= 1'b0;
            busy_r       <= 1'b0;
            halted_r     <= 1'b0;
            carry_flag_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r      <= FETCH;
                        pc_r         <= {PC_W{1'b0}};
                        halted_r     <= 1'b0;
                        carry_flag_r <= 1'b0;
                        instr_req_r  <= 1'b1;
                        busy_r       <= 1'b1;
                    end
                end
                FETCH: begin
                    // Request stays up with no timeout until memory answers
                    if (instr_valid) begin
                        ir_r        <= instr_data;
                        instr_req_r <= 1'b0;
                        state_r     <= DECODE;
                    end
                end
                DECODE: begin
                    if (ir_r == HALT_INSTR) begin
                        halted_r <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        alu_a_r   <= rs1_data_s;
                        alu_b_r   <= imm_s ? imm7_zext(ir_r) : rs2_data_s;
                        alu_sel_r <= op_s;
                        state_r   <= EXEC;
                    end
                end
                EXEC: begin
                    res_r <= alu_out;
                    if (op_s == OP_ADD) begin
                        carry_flag_r <= alu_carry;
                    end
                    state_r <= WB;
                end
                WB: begin
                    // Register write happens in the regfile on this same edge
                    pc_r        <= pc_r + 8'd1;
                    instr_req_r <= 1'b1;
                    state_r     <= FETCH;
                end
                default: begin
                    state_r     <= IDLE;
                    instr_req_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign instr_req  = instr_req_r;
    assign instr_addr = pc_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_sel    = alu_sel_r;
    assign busy       = busy_r;
    assign halted     = halted_r;
    assign carry_flag = carry_flag_r;
    assign pc         = pc_r;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: the bench plays instruction memory and
// the external ALU, predicts each writeback and checks it when it lands.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic [17:0] instr_data;
    logic [17:0] alu_a, alu_b, alu_out;
    logic [1:0]  alu_sel;
    logic        alu_carry;
    logic        busy, halted, carry_flag;
    logic [7:0]  pc;
    logic [3:0]  dbg_addr;
    logic [17:0] dbg_data;

    typedef struct packed {
        logic [3:0]  rd;
        logic [17:0] val;
        logic        carry;
        logic [7:0]  pc;
    } exp_t;

    exp_t        sb_q[$];
    logic [17:0] sh_reg [16];
    logic        sh_carry;
    logic [7:0]  exp_pc;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_exec_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .busy(busy), .halted(halted), .carry_flag(carry_flag), .pc(pc),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference ALU: 00 AND, 01 ADD, 10 OR, 11 XOR; carry only from ADD
    function automatic logic [18:0] alu_ref(input logic [1:0] op,
                                            input logic [17:0] a,
                                            input logic [17:0] b);
        case (op)
            2'b00:   return {1'b0, a & b};
            2'b01:   return {1'b0, a} + {1'b0, b};
            2'b10:   return {1'b0, a | b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    // External ALU driven from the DUT's operand/select outputs
    always_comb begin
        {alu_carry, alu_out} = alu_ref(alu_sel, alu_a, alu_b);
    end

    function automatic logic [17:0] enc(input logic [1:0] op, input logic imm,
                                        input logic [3:0] rd, input logic [3:0] rs1,
                                        input logic [6:0] lo);
        return {op, imm, rd, rs1, lo};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_pc   = 8'd0;
        sh_carry = 1'b0;
    endtask

    // Serve one fetch (optionally stalled), predict the result, then check it
    task automatic issue(input logic [17:0] ins, input int stall);
        int          waited;
        int          t0;
        logic [1:0]  op;
        logic [3:0]  rd, rs1, rs2;
        logic [17:0] b;
        logic [18:0] r;
        exp_t        e;
        waited = 0;
        while (instr_req !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("fetch_req", {31'd0, instr_req}, 32'd1);
        t0 = cyc;
        for (int i = 0; i < stall; i++) begin
            check("stall_req", {31'd0, instr_req}, 32'd1);
            check("stall_addr", {24'd0, instr_addr}, {24'd0, exp_pc});
            check("stall_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check("fetch_addr", {24'd0, instr_addr}, {24'd0, exp_pc});
        instr_valid = 1'b1;
        instr_data  = ins;
        if (ins != 18'h00000) begin
            op  = ins[17:16];
            rd  = ins[14:11];
            rs1 = ins[10:7];
            rs2 = ins[6:3];
            b   = ins[15] ? {11'd0, ins[6:0]} : sh_reg[rs2];
            r   = alu_ref(op, sh_reg[rs1], b);
            if (rd != 4'd0) sh_reg[rd] = r[17:0];
            if (op == 2'b01) sh_carry = r[18];
            exp_pc = exp_pc + 8'd1;
            e.rd = rd; e.val = sh_reg[rd]; e.carry = sh_carry; e.pc = exp_pc;
            sb_q.push_back(e);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        instr_data  = 18'h2AAAA;
        waited = 0;
        if (ins == 18'h00000) begin
            while (busy !== 1'b0 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("halt_busy", {31'd0, busy}, 32'd0);
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_pc", {24'd0, pc}, {24'd0, exp_pc});
        end else begin
            while (instr_req !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("cpi", cyc - t0, 4 + stall);
            if (sb_q.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                dbg_addr = e.rd;
                #1;
                check("wb_data", {14'd0, dbg_data}, {14'd0, e.val});
                check("carry", {31'd0, carry_flag}, {31'd0, e.carry});
                check("wb_pc", {24'd0, pc}, {24'd0, e.pc});
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; instr_valid = 1'b0;
        instr_data = 18'h0; dbg_addr = 4'd5;
        for (int i = 0; i < 16; i++) sh_reg[i] = 18'h0;
        sh_carry = 1'b0; exp_pc = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req", {31'd0, instr_req}, 32'd0);
        check("rst_pc", {24'd0, pc}, 32'd0);
        check("rst_sel", {30'd0, alu_sel}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_dbg", {14'd0, dbg_data}, 32'd0);
        reset = 1'b0;

        // ADD r1,r0,#5 then HALT
        pulse_start();
        issue(18'h18805, 0);
        issue(18'h00000, 0);
        dbg_addr = 4'd1; #1;
        check("t2_r1", {14'd0, dbg_data}, 32'd5);
        check("t2_carry", {31'd0, carry_flag}, 32'd0);
        check("t2_pc", {24'd0, pc}, 32'd1);

        // Build r1 = all ones, then ADD r2=r1+r1 (carry out), XOR keeps carry
        pulse_start();
        issue(enc(2'b10, 1'b1, 4'd1, 4'd0, 7'h7F), 0);
        for (int i = 0; i < 11; i++) begin
            issue(enc(2'b01, 1'b0, 4'd1, 4'd1, {4'd1, 3'd0}), 0);
            issue(enc(2'b10, 1'b1, 4'd1, 4'd1, 7'h7F), 0);
        end
        issue(enc(2'b01, 1'b0, 4'd2, 4'd1, {4'd1, 3'd0}), 0);
        issue(enc(2'b11, 1'b1, 4'd9, 4'd1, 7'h7F), 3);
        dbg_addr = 4'd2; #1;
        check("t3_r2", {14'd0, dbg_data}, 32'h3FFFE);
        check("t3_carry", {31'd0, carry_flag}, 32'd1);
        // Seven-cycle fetch stall
        issue(enc(2'b00, 1'b1, 4'd10, 4'd1, 7'h55), 7);
        issue(18'h00000, 0);

        // r3 = 0x0F0F0, then AND/OR/XOR with #7F and a write to r0
        pulse_start();
        issue(enc(2'b10, 1'b1, 4'd3, 4'd0, 7'h0F), 0);
        for (int i = 0; i < 8; i++) issue(enc(2'b01, 1'b0, 4'd3, 4'd3, {4'd3, 3'd0}), 0);
        issue(enc(2'b10, 1'b1, 4'd3, 4'd3, 7'h0F), 0);
        for (int i = 0; i < 4; i++) issue(enc(2'b01, 1'b0, 4'd3, 4'd3, {4'd3, 3'd0}), 0);
        issue(enc(2'b00, 1'b1, 4'd6, 4'd3, 7'h7F), 1);
        issue(enc(2'b10, 1'b1, 4'd7, 4'd3, 7'h7F), 0);
        issue(enc(2'b11, 1'b1, 4'd8, 4'd3, 7'h7F), 2);
        issue(enc(2'b01, 1'b1, 4'd0, 4'd3, 7'h01), 0);
        issue(18'h00000, 0);
        dbg_addr = 4'd3; #1; check("t5_r3", {14'd0, dbg_data}, 32'h0F0F0);
        dbg_addr = 4'd6; #1; check("t5_and", {14'd0, dbg_data}, 32'h00070);
        dbg_addr = 4'd7; #1; check("t5_or", {14'd0, dbg_data}, 32'h0F0FF);
        dbg_addr = 4'd8; #1; check("t5_xor", {14'd0, dbg_data}, 32'h0F08F);
        dbg_addr = 4'd0; #1; check("t5_r0", {14'd0, dbg_data}, 32'd0);

        // 256 back-to-back RAW increments of r4: pc wraps FF -> 00
        pulse_start();
        for (int i = 0; i < 256; i++) issue(enc(2'b01, 1'b1, 4'd4, 4'd4, 7'h01), 0);
        check("t6_pc_wrap", {24'd0, pc}, 32'd0);
        dbg_addr = 4'd4; #1; check("t6_r4", {14'd0, dbg_data}, 32'd256);
        issue(18'h00000, 0);

        // Reset while in EXEC
        pulse_start();
        check("t1_req", {31'd0, instr_req}, 32'd1);
        instr_valid = 1'b1;
        instr_data  = enc(2'b01, 1'b1, 4'd9, 4'd0, 7'h03);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("t1_sel_exec", {30'd0, alu_sel}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_req0", {31'd0, instr_req}, 32'd0);
        check("t1_pc", {24'd0, pc}, 32'd0);
        check("t1_sel", {30'd0, alu_sel}, 32'd0);
        check("t1_a", {14'd0, alu_a}, 32'd0);
        check("t1_carry", {31'd0, carry_flag}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = i[3:0];
            #1;
            check("t1_reg", {14'd0, dbg_data}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t1_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
